// File: rtl/seven_seg_scanner.sv
// ---------------------------------------------------------------------------
// seven_seg_scanner
//
// Display stage for the 12-hour BCD time-of-day counter. Scans four BCD
// digits (h1 h2 : m1 m2) across a 4-digit common-anode multiplexed
// 7-segment display. It also drives a blinking colon and a PM indicator on
// the m2 decimal point. The digits are snapshotted once per scan frame, so a
// frame never shows a mix of old and new time.
//
// Parameters:
//   REFRESH_DIV    clk cycles per digit slot (>= 2)
//   BLINK_DIV      completed frames per colon half-period (>= 1)
//   SEG_ACTIVE_LOW 1 = seg/dp/colon are low-true
//   AN_ACTIVE_LOW  1 = an is low-true
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   en             scan enable; while low everything holds and outputs are off
//   h1,h2,m1,m2    BCD digits, ap = PM flag
//   seg[6:0]       segments {g,f,e,d,c,b,a}
//   dp             decimal point (on in the m2 slot when PM)
//   an[3:0]        digit enables, an[0] = m2 ... an[3] = h1
//   colon          colon LEDs, toggles every BLINK_DIV frames
//   frame_done     1-cycle pulse in the cycle after each frame wrap
//
// All outputs are registered. They show the scan state one cycle after the
// state register moves.
// ---------------------------------------------------------------------------
module seven_seg_scanner #(
  parameter int REFRESH_DIV    = 50000,
  parameter int BLINK_DIV      = 250,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] h1,
  input  logic [3:0] h2,
  input  logic [3:0] m1,
  input  logic [3:0] m2,
  input  logic       ap,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       colon,
  output logic       frame_done
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic [1:0] {
    D0 = 2'd0,  // m2
    D1 = 2'd1,  // m1
    D2 = 2'd2,  // h2
    D3 = 2'd3   // h1
  } scan_state_t;

  // Segment patterns are kept active-high internally. The polarity is
  // applied once, at the output register.
  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;  // dash: non-BCD input
    endcase
    return s;
  endfunction

  // State
  logic [CW-1:0] cnt_q, cnt_d;
  scan_state_t   state_q, state_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_phase_q, blink_phase_d;
  logic [3:0]    sh_h1_q, sh_h1_d, sh_h2_q, sh_h2_d;
  logic [3:0]    sh_m1_q, sh_m1_d, sh_m2_q, sh_m2_d;
  logic          sh_ap_q, sh_ap_d;
  logic          load_pending_q, load_pending_d;

  // Registered outputs, physical polarity
  logic [6:0] seg_q, seg_d;
  logic       dp_q, dp_d;
  logic [3:0] an_q, an_d;
  logic       colon_q, colon_d;
  logic       frame_done_q, frame_done_d;

  // Combinational helpers
  logic       slot_tick;
  logic       wrap;
  logic       load;
  logic [3:0] src_h1, src_h2, src_m1, src_m2;
  logic       src_ap;
  logic [3:0] sel_digit;
  logic [6:0] seg_l;
  logic [3:0] an_l;
  logic       dp_l;
  logic       colon_l;

  always_comb begin
    cnt_d          = cnt_q;
    state_d        = state_q;
    blink_cnt_d    = blink_cnt_q;
    blink_phase_d  = blink_phase_q;
    sh_h1_d        = sh_h1_q;
    sh_h2_d        = sh_h2_q;
    sh_m1_d        = sh_m1_q;
    sh_m2_d        = sh_m2_q;
    sh_ap_d        = sh_ap_q;
    load_pending_d = load_pending_q;

    slot_tick = en && (cnt_q == CW'(REFRESH_DIV - 1));
    wrap      = slot_tick && (state_q == D3);
    load      = wrap || (en && load_pending_q);

    // Prescaler
    if (en) begin
      cnt_d = slot_tick ? '0 : cnt_q + CW'(1);
    end

    // Scan order m2 -> m1 -> h2 -> h1 -> m2
    if (slot_tick) begin
      case (state_q)
        D0:      state_d = D1;
        D1:      state_d = D2;
        D2:      state_d = D3;
        default: state_d = D0;
      endcase
    end

    // Snapshot. Both load causes require en, so either one satisfies the
    // pending request.
    if (load) begin
      sh_h1_d        = h1;
      sh_h2_d        = h2;
      sh_m1_d        = m1;
      sh_m2_d        = m2;
      sh_ap_d        = ap;
      load_pending_d = 1'b0;
    end

    // Colon blink, counted in frames
    if (wrap) begin
      if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d   = blink_cnt_q + BW'(1);
      end
    end

    // On the pending first-enable load, the shadow is written at this same
    // edge. Display the incoming values directly, so the first slot after
    // enable already shows the captured time and not the reset zeros.
    src_h1 = load_pending_q ? h1 : sh_h1_q;
    src_h2 = load_pending_q ? h2 : sh_h2_q;
    src_m1 = load_pending_q ? m1 : sh_m1_q;
    src_m2 = load_pending_q ? m2 : sh_m2_q;
    src_ap = load_pending_q ? ap : sh_ap_q;

    case (state_q)
      D0:      sel_digit = src_m2;
      D1:      sel_digit = src_m1;
      D2:      sel_digit = src_h2;
      default: sel_digit = src_h1;
    endcase

    // Logical (active-high) output levels
    an_l         = 4'b0000;
    seg_l        = 7'h00;
    dp_l         = 1'b0;
    colon_l      = 1'b0;
    frame_done_d = 1'b0;
    if (en) begin
      an_l         = 4'b0001 << state_q;
      seg_l        = decode(sel_digit);
      dp_l         = (state_q == D0) && src_ap;
      colon_l      = blink_phase_q;
      frame_done_d = wrap;
      // Leading-zero blank on the hour tens digit
      if ((state_q == D3) && (src_h1 == 4'd0)) begin
        an_l  = 4'b0000;
        seg_l = 7'h00;
      end
    end

    an_d    = an_l ^ {4{AN_ACTIVE_LOW}};
    seg_d   = seg_l ^ {7{SEG_ACTIVE_LOW}};
    dp_d    = dp_l ^ SEG_ACTIVE_LOW;
    colon_d = colon_l ^ SEG_ACTIVE_LOW;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q          <= '0;
      state_q        <= D0;
      blink_cnt_q    <= '0;
      blink_phase_q  <= 1'b0;
      sh_h1_q        <= 4'd0;
      sh_h2_q        <= 4'd0;
      sh_m1_q        <= 4'd0;
      sh_m2_q        <= 4'd0;
      sh_ap_q        <= 1'b0;
      load_pending_q <= 1'b1;
      an_q           <= {4{AN_ACTIVE_LOW}};
      seg_q          <= {7{SEG_ACTIVE_LOW}};
      dp_q           <= SEG_ACTIVE_LOW;
      colon_q        <= SEG_ACTIVE_LOW;
      frame_done_q   <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      state_q        <= state_d;
      blink_cnt_q    <= blink_cnt_d;
      blink_phase_q  <= blink_phase_d;
      sh_h1_q        <= sh_h1_d;
      sh_h2_q        <= sh_h2_d;
      sh_m1_q        <= sh_m1_d;
      sh_m2_q        <= sh_m2_d;
      sh_ap_q        <= sh_ap_d;
      load_pending_q <= load_pending_d;
      an_q           <= an_d;
      seg_q          <= seg_d;
      dp_q           <= dp_d;
      colon_q        <= colon_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign colon      = colon_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// ---------------------------------------------------------------------------
// tb_seven_seg_scanner
//
// The driver sets inputs on the falling edge. A reference model then
// predicts the output vector that appears after the next rising edge and
// pushes it into exp_q. A separate monitor samples 1 time unit after each
// rising edge, pops one entry and compares. The model tracks the frame as a
// plain cycle position (0 .. 4*RD-1) and the blink phase as a count of
// completed frames.
// ---------------------------------------------------------------------------
module tb_seven_seg_scanner;

  localparam int RD  = 4;
  localparam int BD  = 2;
  localparam int FW  = 4 * RD;  // cycles per frame
  localparam bit SAL = 1'b0;
  localparam bit AAL = 1'b0;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       en;
  logic [3:0] h1, h2, m1, m2;
  logic       ap;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       colon;
  logic       frame_done;

  seven_seg_scanner #(
    .REFRESH_DIV   (RD),
    .BLINK_DIV     (BD),
    .SEG_ACTIVE_LOW(SAL),
    .AN_ACTIVE_LOW (AAL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .h1        (h1),
    .h2        (h2),
    .m1        (m1),
    .m2        (m2),
    .ap        (ap),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .colon     (colon),
    .frame_done(frame_done)
  );

  // Scoreboard: {an[3:0], seg[6:0], dp, colon, frame_done}
  logic [13:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state
  int         pos;        // cycle within the frame
  int         frames;     // completed frames
  logic [3:0] snap[4];    // index 0 = m2 ... 3 = h1
  logic       snap_ap;
  bit         pending;

  logic [6:0] seg_tab[10];
  initial begin
    seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  end

  function automatic logic [6:0] ref_seg(input logic [3:0] d);
    if (d < 4'd10) return seg_tab[d];
    return 7'h40;
  endfunction

  // Predicts the outputs after the next rising edge from the present
  // inputs, then advances the model by one cycle.
  task automatic model_step();
    logic [3:0] cur[4];
    logic [3:0] use_d[4];
    logic       use_ap;
    int         dig;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp, e_colon, e_fd;
    cur[0] = m2; cur[1] = m1; cur[2] = h2; cur[3] = h1;
    e_an = 4'b0000; e_seg = 7'h00; e_dp = 1'b0; e_colon = 1'b0; e_fd = 1'b0;
    if (reset) begin
      pos = 0; frames = 0; pending = 1'b1; snap_ap = 1'b0;
      for (int i = 0; i < 4; i++) snap[i] = 4'd0;
    end else if (en) begin
      for (int i = 0; i < 4; i++) use_d[i] = pending ? cur[i] : snap[i];
      use_ap = pending ? ap : snap_ap;
      dig = pos / RD;
      if (dig == 3 && use_d[3] == 4'd0) begin
        e_an = 4'b0000; e_seg = 7'h00;
      end else begin
        e_an = 4'(1 << dig); e_seg = ref_seg(use_d[dig]);
      end
      e_dp    = (dig == 0) && use_ap;
      e_colon = ((frames / BD) % 2) == 1;
      e_fd    = (pos == FW - 1);
      if (pending || pos == FW - 1) begin
        for (int i = 0; i < 4; i++) snap[i] = cur[i];
        snap_ap = ap;
        pending = 1'b0;
      end
      if (pos == FW - 1) frames++;
      pos = (pos + 1) % FW;
    end
    exp_q.push_back({e_an ^ {4{AAL}}, e_seg ^ {7{SAL}}, e_dp ^ SAL,
                     e_colon ^ SAL, e_fd});
  endtask

  // Monitor
  always @(posedge clk) begin
    logic [13:0] e, g;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = {an, seg, dp, colon, frame_done};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL outputs t=%0t got an=%b seg=%h dp=%b colon=%b fd=%b exp an=%b seg=%h dp=%b colon=%b fd=%b",
                 $time, g[13:10], g[9:3], g[2], g[1], g[0],
                 e[13:10], e[9:3], e[2], e[1], e[0]);
      end
    end
  end

  // Driver tasks (called while positioned at a falling edge)
  task automatic run(input int n);
    repeat (n) begin
      model_step();
      @(negedge clk);
    end
  endtask

  task automatic run_until_digit(input int d);
    int guard;
    guard = 0;
    while ((pos / RD) != d && guard < 2 * FW) begin
      run(1);
      guard++;
    end
  endtask

  task automatic set_digits(input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [3:0] d,
                            input logic p);
    h1 = a; h2 = b; m1 = c; m2 = d; ap = p;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0;
    set_digits(4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    pos = 0; frames = 0; pending = 1'b1; snap_ap = 1'b0;
    for (int i = 0; i < 4; i++) snap[i] = 4'd0;
    @(negedge clk);
    run(2);

    // 12:59 PM
    reset = 1'b0;
    set_digits(4'd1, 4'd2, 4'd5, 4'd9, 1'b1);
    en = 1'b1;
    run(2 * FW);

    // 09:47 AM: leading-zero blank on h1
    set_digits(4'd0, 4'd9, 4'd4, 4'd7, 1'b0);
    run(2 * FW);

    // m2 changes in the middle of a frame and waits for the wrap
    set_digits(4'd1, 4'd1, 4'd2, 4'd3, 1'b0);
    run_until_digit(0);
    run(FW);
    run_until_digit(1);
    m2 = 4'd4;
    run(2 * FW);

    // colon blink over several frames
    run(4 * FW);

    // enable dropped mid-D2
    run_until_digit(2);
    run(1);
    en = 1'b0;
    run(10);
    en = 1'b1;
    run(FW);

    // reset during D3 with a non-BCD m2
    run_until_digit(3);
    m2 = 4'hC;
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    run(2 * FW);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 15) == 0) en = ~en;
      if ($urandom_range(0, 7) == 0)
        set_digits(4'($urandom_range(0, 15)), 4'($urandom_range(0, 9)),
                   4'($urandom_range(0, 9)), 4'($urandom_range(0, 15)),
                   1'($urandom_range(0, 1)));
      reset = ($urandom_range(0, 199) == 0);
      run(1);
    end
    reset = 1'b0;
    run(2);

    // let the monitor drain the last entry
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got %0d entries left exp 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
